riscv_mem_model: RTL
====================

// Module: riscv_mem_model
// PURPOSE
//  Parametrised dual-port memory model behind riscv_small: instruction and data ports onto one word array.
//  Each port has its own programmable wait-state latency. The data port does byte/half/word writes with lane enables.
//  The array is preloaded from a hex image. Replaces the fixed-latency single-purpose inst/data memories in the bench.
// PARAMETERS
//  DATA_WIDTH   32            word width in bits; fixed to 32 in this revision
//  DEPTH_WORDS  4096          array depth in words; addresses wrap modulo DEPTH_WORDS
//  INST_LAT     1             cycles from accepted inst request to inst_ready (1..15)
//  DATA_LAT     1             cycles from accepted data request to data_ready (1..15)
//  PROGRAM_HEX  ""            $readmemh image; an empty string leaves the array as X
//  TOHOST_ADDR  32'h0000_1000 byte address of the tohost word (used only with RISCV_MEM_TOHOST_EN)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous reset, active-high
//  clk_en          in   1   clock enable; when low, all state holds
//  inst_rd_en      in   1   instruction read request
//  inst_addr       in   32  instruction byte address; bits [1:0] ignored
//  inst_data       out  32  instruction word
//  inst_ready      out  1   one-cycle pulse; inst_data valid
//  data_rd_en      in   1   data read request
//  data_wr_en      in   1   data write request
//  data_rd_wr_ctrl in   2   00 byte, 01 half, 10 word, 11 illegal
//  data_addr       in   32  data byte address
//  data_wr         in   32  write data, right-aligned
//  data_rd         out  32  aligned word read; the core extracts lanes
//  data_ready      out  1   one-cycle completion pulse
//  data_misalign   out  1   pulses with data_ready when the access was misaligned or illegal
//  test_done       out  1   sticky; tohost write seen
//  test_pass       out  1   sticky; tohost value == 1
//  test_code       out  31  tohost[31:1] of the first tohost write
// BEHAVIOUR
//  - Reset: all outputs 0, both port FSMs IDLE, counters 0. Array contents are not cleared.
//  - Per-port FSM IDLE->WAIT->RESP->IDLE:
//    - IDLE: on a request, latch addr/ctrl/wdata and load cnt=LAT-1. Go to RESP if cnt==0, else WAIT.
//    - WAIT: decrement cnt each enabled cycle; go to RESP when it reaches 0.
//    - RESP: assert ready for one cycle with data, then return to IDLE.
//  - Latency from accept to ready is exactly LAT cycles. Requests while not IDLE are ignored.
//  - A request held high after RESP is accepted as a new request in the next IDLE cycle.
//  - data_rd_en and data_wr_en both high: treated as a write; the read is ignored.
//  - Writes commit on the RESP cycle with lane enables:
//    - byte: data_wr[7:0] to lane addr[1:0]
//    - half: data_wr[15:0] to lanes {addr[1],0}
//    - word: all lanes
//  - Misaligned or illegal access: half with addr[0]=1, word with addr[1:0]!=0, or ctrl=11.
//    No write happens; data_rd=0; data_misalign=1 with data_ready.
//  - Read data is sampled from the array on the RESP cycle.
//  - Same-word collision (inst RESP and data write commit in the same cycle): inst_data returns the pre-write word.
//    A data read and write cannot overlap, since there is only one data FSM.
//  - Reset mid-access: the pending access is dropped, with no write and no ready.
//  - clk_en=0: FSMs, counters and outputs hold. A RESP pulse is stretched until clk_en returns.
//  - Array index is addr[2+:$clog2(DEPTH_WORDS)]; higher bits are ignored (wrap).
// CONFIGURATION
//  - RISCV_MEM_TOHOST_EN defined:
//    - A committed word write to TOHOST_ADDR sets test_done.
//    - test_pass = (data_wr == 1); test_code = data_wr[31:1].
//    - Later tohost writes do not change the flags. The write still goes to the array.
//  - Not defined: test_done, test_pass and test_code are tied 0 and TOHOST_ADDR is unused.
//    The port list is unchanged.
// STRUCTURE
//  - riscv_definitions gains:
//    - mem_size_e {MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10}
//    - mem_port_state_e {MP_IDLE, MP_WAIT, MP_RESP}
//    - function mem_lane_mask(size, addr[1:0]) returning a 4-bit byte-enable, 0 when misaligned
//  - Sub-module riscv_mem_port_timer holds the latency FSM and counter. It is instantiated twice (inst, data).
//    It has parameter LAT and ports req, accept, resp. The top level holds the array, lane logic and tohost.
// TESTING
//  - Preload word0=32'h0000_0513, inst_rd_en=1, addr=0, INST_LAT=3 -> inst_ready exactly 3 cycles after accept with 32'h0000_0513.
//  - Byte write 8'hAB to addr 0x102, then word read of 0x100 (preload 0) -> data_rd=32'h00AB_0000, data_misalign=0.
//  - Half write to 0x101 -> data_misalign=1 with data_ready; a following read of 0x100 is unchanged.
//  - Same cycle: inst read of 0x200 and data word write 32'hDEAD_BEEF to 0x200 -> inst_data=old word; next inst read returns DEADBEEF.
//  - rst=1 during data WAIT (DATA_LAT=4) -> no data_ready, target word unchanged, all outputs 0 the next cycle.
//  - RISCV_MEM_TOHOST_EN: write 1 to TOHOST_ADDR -> test_done=1, test_pass=1; a later write of 7 leaves test_code=0.

Source files
------------

// File: rtl/riscv_mem_model_pkg.sv
// rtl/riscv_mem_model_pkg.sv - shared types and lane-mask helper for the memory model
//
// Purpose: access-size and port-state encodings, plus the byte-enable helper
// used by the data port of riscv_mem_model.
// Ports: none (package).
package riscv_mem_model_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_WAIT = 2'd1,
    MP_RESP = 2'd2
  } mem_port_state_e;

  // Byte enables for an access; an all-zero mask marks a misaligned or
  // illegal (size 11) access.
  function automatic logic [3:0] mem_lane_mask(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      MEM_B:   mask = 4'b0001 << addr;
      MEM_H:   if (!addr[0]) mask = addr[1] ? 4'b1100 : 4'b0011;
      MEM_W:   if (addr == 2'b00) mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/riscv_mem_model_if.sv
// rtl/riscv_mem_model_if.sv - instruction and data port bundle of the memory model
//
// Purpose: groups the instruction-fetch and data-access handshakes.
// Signals:
//   inst_rd_en/inst_addr        master -> slave  instruction read request
//   inst_data/inst_ready        slave -> master  instruction word and one-cycle pulse
//   data_rd_en/data_wr_en       master -> slave  data read/write request
//   data_rd_wr_ctrl             master -> slave  00 byte, 01 half, 10 word, 11 illegal
//   data_addr/data_wr           master -> slave  byte address and right-aligned write data
//   data_rd/data_ready          slave -> master  aligned read word and completion pulse
//   data_misalign               slave -> master  misaligned/illegal flag with data_ready
interface riscv_mem_model_if;

  logic        inst_rd_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ready;

  logic        data_rd_en;
  logic        data_wr_en;
  logic [1:0]  data_rd_wr_ctrl;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        data_ready;
  logic        data_misalign;

  modport master (
    output inst_rd_en, inst_addr,
    input  inst_data, inst_ready,
    output data_rd_en, data_wr_en, data_rd_wr_ctrl, data_addr, data_wr,
    input  data_rd, data_ready, data_misalign
  );

  modport slave (
    input  inst_rd_en, inst_addr,
    output inst_data, inst_ready,
    input  data_rd_en, data_wr_en, data_rd_wr_ctrl, data_addr, data_wr,
    output data_rd, data_ready, data_misalign
  );

endinterface

// File: rtl/riscv_mem_model_port_timer.sv
// rtl/riscv_mem_model_port_timer.sv - per-port wait-state FSM (IDLE -> WAIT -> RESP)
//
// Purpose: times one memory port so that ready follows an accepted request by
// exactly LAT cycles (LAT in 1..15).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clk_en     when low, state and counter hold (RESP is stretched)
//   req        request from the port
//   accept     high in the IDLE cycle where req is taken; owner latches operands
//   resp       high during the RESP cycle
module riscv_mem_port_timer
  import riscv_mem_model_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic req,
  output logic accept,
  output logic resp
);

  localparam logic [1:0] S_IDLE = MP_IDLE;
  localparam logic [1:0] S_WAIT = MP_WAIT;
  localparam logic [1:0] S_RESP = MP_RESP;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  assign accept = clk_en && (state == S_IDLE) && req;
  assign resp   = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (req) begin
            cnt   <= CNT_LOAD;
            state <= (CNT_LOAD == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // The edge that brings cnt to zero is the one that enters RESP.
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_model.sv
// rtl/riscv_mem_model.sv - dual-port (inst/data) word memory with programmable wait states
//
// Purpose: one word array shared by an instruction read port and a byte/half/word
// data port, each with its own latency; optional tohost detection.
// Optional feature: RISCV_MEM_TOHOST_EN enables the tohost flags; otherwise they read 0.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   clk_en         clock enable; when low all state holds
//   bus            riscv_mem_model_if.slave (instruction and data ports)
//   test_done      sticky, a word write to TOHOST_ADDR was committed
//   test_pass      sticky, first tohost value was 1
//   test_code      tohost[31:1] of the first tohost write
module riscv_mem_model
  import riscv_mem_model_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          INST_LAT    = 1,
  parameter int          DATA_LAT    = 1,
  parameter string       PROGRAM_HEX = "",
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  riscv_mem_model_if.slave    bus,
  output logic                test_done,
  output logic                test_pass,
  output logic [30:0]         test_code
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic inst_accept, inst_resp;
  logic data_accept, data_resp;
  logic data_req;

  assign data_req = bus.data_rd_en | bus.data_wr_en;

  riscv_mem_port_timer #(.LAT(INST_LAT)) u_inst_timer (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .req    (bus.inst_rd_en),
    .accept (inst_accept),
    .resp   (inst_resp)
  );

  riscv_mem_port_timer #(.LAT(DATA_LAT)) u_data_timer (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .req    (data_req),
    .accept (data_accept),
    .resp   (data_resp)
  );

  // Operands captured at accept; outputs are gated by resp, so no reset needed.
  logic [31:0] inst_addr_q;
  logic [31:0] data_addr_q;
  logic [1:0]  data_ctrl_q;
  logic [31:0] data_wdata_q;
  logic        data_is_wr_q;

  always_ff @(posedge clk) begin
    if (inst_accept) inst_addr_q <= bus.inst_addr;
    if (data_accept) begin
      data_addr_q  <= bus.data_addr;
      data_ctrl_q  <= bus.data_rd_wr_ctrl;
      data_wdata_q <= bus.data_wr;
      data_is_wr_q <= bus.data_wr_en;  // write wins when both enables are high
    end
  end

  logic [AW-1:0] inst_idx, data_idx;
  logic [3:0]    lane_mask;
  logic          misalign;
  logic [31:0]   wr_lanes;
  logic          commit;

  assign inst_idx  = inst_addr_q[2 +: AW];
  assign data_idx  = data_addr_q[2 +: AW];
  assign lane_mask = mem_lane_mask(data_ctrl_q, data_addr_q[1:0]);
  assign misalign  = (lane_mask == 4'b0000);

  // Replicate the right-aligned write data across lanes; the mask selects.
  always_comb begin
    wr_lanes = data_wdata_q;
    case (data_ctrl_q)
      MEM_B:   wr_lanes = {4{data_wdata_q[7:0]}};
      MEM_H:   wr_lanes = {2{data_wdata_q[15:0]}};
      default: wr_lanes = data_wdata_q;
    endcase
  end

  // Commit at the edge that ends RESP, so any RESP read in that cycle
  // (including an inst read of the same word) still sees the old contents.
  assign commit = data_resp && clk_en && !rst && data_is_wr_q && !misalign;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[data_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign bus.inst_ready    = inst_resp;
  assign bus.inst_data     = inst_resp ? mem[inst_idx] : 32'h0;
  assign bus.data_ready    = data_resp;
  assign bus.data_misalign = data_resp && misalign;
  assign bus.data_rd       = (data_resp && !misalign) ? mem[data_idx] : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{inst_addr_q[1:0], inst_addr_q[31:AW+2], data_addr_q[31:AW+2]};

`ifdef RISCV_MEM_TOHOST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
      test_code <= 31'h0;
    end else if (commit && lane_mask == 4'b1111 && data_addr_q == TOHOST_ADDR && !test_done) begin
      test_done <= 1'b1;
      test_pass <= (data_wdata_q == 32'h1);
      test_code <= data_wdata_q[31:1];
    end
  end
`else
  assign test_done = 1'b0;
  assign test_pass = 1'b0;
  assign test_code = 31'h0;

  logic unused_tohost;
  assign unused_tohost = ^TOHOST_ADDR;
`endif

endmodule
